cpc_bus_initiator: RTL and testbench
====================================

# cpc_bus_initiator

Z80-style bus cycle initiator for the CPC expansion bench and the bus-master test fixture. It accepts one command at a time on a valid/ready port and drives a T-state-accurate memory read, memory write, IO write or M1 fetch with refresh onto the expansion bus. The RAM expansion CPLD observes these cycles as it would on a real CPC. Bank selection is therefore an IOWR to 0x7Fxx with data 0b11cccbbb, issued through this block.

## Interface
- No parameters.
- clk  in  1  CPU clock; one clk period = one T-state; all outputs registered on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; transfer on cmd_valid & cmd_ready at rising edge.
- cmd_op  in  2  00 MEMRD, 01 MEMWR, 10 IOWR, 11 M1 fetch.
- cmd_addr  in  16  cycle address.
- cmd_wdata  in  8  write data (MEMWR/IOWR).
- rsp_valid  out  1  one-cycle completion pulse, every command.
- rsp_rdata  out  8  read data; updated only by MEMRD/M1, held otherwise.
- adr  out  16  bus address.
- data_out  out  8  bus write data.
- data_oe  out  1  data_out drive enable.
- data_in  in  8  bus read data.
- mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b  out  1 each  active-low bus strobes.
- wait_b  in  1  low requests wait states.
- r_reg  out  7  refresh counter.

## Operation
- FSM states: IDLE, T1, T2, TW, T3, T4. Command fields are latched on acceptance. The next state is T1.
- MEMRD:
  - T1/T2/TW/T3: adr=A, mreq_b=0, rd_b=0.
  - End of T2 and end of each TW: wait_b=0 → TW, else → T3.
  - End of T3: rsp_rdata←data_in, then IDLE.
- MEMWR:
  - T1: adr=A, data_out=D, data_oe=1, mreq_b=0, wr_b=1.
  - T2/TW/T3: as T1 with wr_b=0.
  - Wait rule as MEMRD.
  - Exit T3 → IDLE; strobes high, data_oe=0.
- IOWR:
  - T1: adr=A, data_out=D, data_oe=1, iorq_b=1.
  - T2/TW/T3: iorq_b=0, wr_b=0.
  - End of T2 always → TW (one automatic wait).
  - End of each TW: wait_b=0 → TW, else → T3.
  - Exit T3 → IDLE.
- M1:
  - T1/T2/TW: adr=A, m1_b=0, mreq_b=0, rd_b=0. Wait rule as MEMRD.
  - rsp_rdata←data_in at end of T2, or at end of the last TW.
  - T3: adr={9'b0,r_reg}, rfsh_b=0, mreq_b=0, m1_b=1, rd_b=1.
  - T4: rfsh_b=0, mreq_b=1.
  - Exit T4 → IDLE; r_reg←r_reg+1, mod 128 (127→0).
- rsp_valid=1 for exactly the IDLE cycle following the final T-state. A new command may be accepted in that same cycle.
- All strobes are high in IDLE, so every cycle starts with a fresh mreq_b/iorq_b falling edge and rfsh_b=1 at the MEMRD/MEMWR mreq_b fall.
- adr and data_out hold their last values in IDLE; data_oe=0 in IDLE.

## Timing
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0.
  - adr=0, data_out=0, data_oe=0.
  - all strobes=1, r_reg=0, state IDLE.
- Reset mid-cycle aborts immediately and asynchronously: strobes high, data_oe=0, no rsp_valid, r_reg cleared.
- Cycle lengths from acceptance edge to rsp_valid, counting T-states:
  - MEMRD/MEMWR: 3+N.
  - IOWR: 4+N.
  - M1: 4+N.
  - N = number of wait_b-low samples.
- Minimum one IDLE T-state between consecutive commands. Back-to-back throughput: MEMRD/MEMWR every 4 clk.
- wait_b is sampled only at the stated edges; it is ignored in T1, T3, T4 and IDLE.
- cmd_valid with cmd_ready=0 is ignored; no command queueing.

## Test plan
- IOWR 0x7F00, data 0xC2:
  - iorq_b low for 3 clk (T2, TW, T3); wr_b low with it; data_out=0xC2 with data_oe=1 from T1 to T3.
  - rsp_valid 4 clk after acceptance.
- MEMWR 0xC000 data 0x5A, then MEMRD 0xC000 with data_in=0x5A:
  - Write: mreq_b low 3 clk, wr_b low 2 clk.
  - Read: rd_b low 3 clk, rsp_rdata=0x5A.
  - rsp_valid 4 clk apart.
- MEMRD 0x4000 with wait_b held low 2 clk from T2: two TW states, mreq_b low 5 clk, rsp_valid 5 clk after acceptance.
- 130 consecutive M1 fetches:
  - refresh adr low byte runs 0x00..0x7F, then 0x00, 0x01.
  - rfsh_b low exactly T3–T4 each time; m1_b never low while rfsh_b low.
- Assert reset_b during MEMWR T2: strobes high and data_oe=0 without waiting for clk; no rsp_valid; after release cmd_ready=1 and r_reg=0.

Source files
------------

// File: rtl/cpc_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : cpc_bus_initiator
// Purpose  : Z80-style T-state bus cycle generator (MEMRD, MEMWR, IOWR, M1+RFSH)
// Revision : 1.0
// ============================================================================
module cpc_bus_initiator (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] adr,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        mreq_b,
    output logic        iorq_b,
    output logic        rd_b,
    output logic        wr_b,
    output logic        m1_b,
    output logic        rfsh_b,
    input  logic        wait_b,
    output logic [6:0]  r_reg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5
    } state_t;

    localparam logic [1:0] OP_MEMRD = 2'b00;
    localparam logic [1:0] OP_MEMWR = 2'b01;
    localparam logic [1:0] OP_IOWR  = 2'b10;
    localparam logic [1:0] OP_M1    = 2'b11;

    state_t     state;
    logic [1:0] op;
    logic       wait_done;

    // IO cycles always insert one wait state after T2 regardless of wait_b.
    assign wait_done = wait_b && !(state == S_T2 && op == OP_IOWR);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= S_IDLE;
            op        <= OP_MEMRD;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            adr       <= 16'h0000;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            mreq_b    <= 1'b1;
            iorq_b    <= 1'b1;
            rd_b      <= 1'b1;
            wr_b      <= 1'b1;
            m1_b      <= 1'b1;
            rfsh_b    <= 1'b1;
            r_reg     <= 7'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op        <= cmd_op;
                        adr       <= cmd_addr;
                        cmd_ready <= 1'b0;
                        state     <= S_T1;
                        case (cmd_op)
                            OP_MEMRD: begin
                                mreq_b <= 1'b0;
                                rd_b   <= 1'b0;
                            end
                            OP_MEMWR: begin
                                mreq_b   <= 1'b0;
                                data_out <= cmd_wdata;
                                data_oe  <= 1'b1;
                            end
                            OP_IOWR: begin
                                data_out <= cmd_wdata;
                                data_oe  <= 1'b1;
                            end
                            default: begin
                                m1_b   <= 1'b0;
                                mreq_b <= 1'b0;
                                rd_b   <= 1'b0;
                            end
                        endcase
                    end
                end

                S_T1: begin
                    state <= S_T2;
                    if (op == OP_MEMWR || op == OP_IOWR) begin
                        wr_b <= 1'b0;
                    end
                    if (op == OP_IOWR) begin
                        iorq_b <= 1'b0;
                    end
                end

                S_T2, S_TW: begin
                    if (wait_done) begin
                        state <= S_T3;
                        // Opcode fetch completes here; T3/T4 become the refresh slot.
                        if (op == OP_M1) begin
                            rsp_rdata <= data_in;
                            adr       <= {9'd0, r_reg};
                            m1_b      <= 1'b1;
                            rd_b      <= 1'b1;
                            rfsh_b    <= 1'b0;
                        end
                    end else begin
                        state <= S_TW;
                    end
                end

                S_T3, S_T4: begin
                    if (state == S_T3 && op == OP_M1) begin
                        state  <= S_T4;
                        mreq_b <= 1'b1;
                    end else begin
                        if (op == OP_MEMRD) begin
                            rsp_rdata <= data_in;
                        end
                        if (op == OP_M1) begin
                            r_reg <= r_reg + 7'd1;
                        end
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        data_oe   <= 1'b0;
                        mreq_b    <= 1'b1;
                        iorq_b    <= 1'b1;
                        rd_b      <= 1'b1;
                        wr_b      <= 1'b1;
                        m1_b      <= 1'b1;
                        rfsh_b    <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpc_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpc_bus_initiator
// Purpose  : Directed bench with a per-cycle expected-bus-trace model
// Revision : 1.0
// ============================================================================
module tb_cpc_bus_initiator;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] adr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in = 8'h00;
    logic        mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b;
    logic        wait_b = 1'b1;
    logic [6:0]  r_reg;

    cpc_bus_initiator dut (
        .clk(clk), .reset_b(reset_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .adr(adr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b),
        .m1_b(m1_b), .rfsh_b(rfsh_b), .wait_b(wait_b), .r_reg(r_reg)
    );

    always #5 clk = ~clk;

    localparam int PH_T1 = 1, PH_T2 = 2, PH_TW = 3, PH_T3 = 4, PH_T4 = 5;

    int vectors = 0;
    int miscompares = 0;
    int cnt_mreq = 0, cnt_iorq = 0, cnt_rd = 0, cnt_wr = 0, cnt_rfsh = 0, cnt_overlap = 0;

    logic [47:0] expq[$];
    logic [15:0] m_adr = 16'h0000;
    logic [7:0]  m_dout = 8'h00;
    logic [7:0]  m_rdata = 8'h00;
    logic [6:0]  m_r = 7'd0;

    logic [47:0] act_vec;
    assign act_vec = {adr, data_out, data_oe, mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b,
                      cmd_ready, rsp_valid, rsp_rdata, r_reg};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pack(input logic [15:0] a, input logic [7:0] dout,
                                         input logic oe, input logic [5:0] strb,
                                         input logic rdy, input logic vld,
                                         input logic [7:0] rdat, input logic [6:0] r);
        return {a, dout, oe, strb, rdy, vld, rdat, r};
    endfunction

    // Strobe counters and the per-cycle trace compare.
    always @(negedge clk) begin : compare
        logic [47:0] e;
        if (reset_b) begin
            if (!mreq_b) cnt_mreq++;
            if (!iorq_b) cnt_iorq++;
            if (!rd_b)   cnt_rd++;
            if (!wr_b)   cnt_wr++;
            if (!rfsh_b) cnt_rfsh++;
            if (!m1_b && !rfsh_b) cnt_overlap++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("cycle", {16'h0, act_vec}, {16'h0, e});
            end
        end
    end

    // Called in an IDLE cycle at posedge+2; returns at posedge+2 of the response cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] rd, input int n, input bit noise);
        int w, len, cap, s, ph;
        logic [15:0] ea;
        logic        is_wr, is_m1;
        is_wr = (op == 2'b01 || op == 2'b10);
        is_m1 = (op == 2'b11);
        w   = n + ((op == 2'b10) ? 1 : 0);
        len = 3 + w + (is_m1 ? 1 : 0);
        cap = is_m1 ? 2 + n : len;
        s   = (op == 2'b10) ? 3 : 2;
        ea  = a;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        wait_b = noise ? 1'b0 : 1'b1;
        data_in = ~rd;
        @(posedge clk); #2;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_addr = ~a; cmd_wdata = ~d;
        for (int k = 1; k <= len; k++) begin
            if (k == 1)           ph = PH_T1;
            else if (k == 2)      ph = PH_T2;
            else if (k <= 2 + w)  ph = PH_TW;
            else if (k == 3 + w)  ph = PH_T3;
            else                  ph = PH_T4;
            ea = (is_m1 && ph >= PH_T3) ? {9'd0, m_r} : a;
            expq.push_back(pack(ea, is_wr ? d : m_dout, is_wr,
                {(op == 2'b10) || (is_m1 && ph == PH_T4),
                 !(op == 2'b10 && ph != PH_T1),
                 !(op == 2'b00 || (is_m1 && ph <= PH_TW)),
                 !(is_wr && ph != PH_T1),
                 !(is_m1 && ph <= PH_TW),
                 !(is_m1 && ph >= PH_T3)},
                1'b0, 1'b0, (is_m1 && k > cap) ? rd : m_rdata, m_r));
        end
        m_adr = ea;
        if (is_wr) m_dout = d;
        if (op == 2'b00 || is_m1) m_rdata = rd;
        if (is_m1) m_r = m_r + 7'd1;
        expq.push_back(pack(m_adr, m_dout, 1'b0, 6'b111111, 1'b1, 1'b1, m_rdata, m_r));
        for (int k = 1; k <= len; k++) begin
            if (k >= s && k < s + n) wait_b = 1'b0;
            else if (k == s + n)     wait_b = 1'b1;
            else                     wait_b = noise ? 1'b0 : 1'b1;
            data_in = (!noise || k == cap) ? rd : ~rd;
            @(posedge clk); #2;
        end
        wait_b = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            expq.push_back(pack(m_adr, m_dout, 1'b0, 6'b111111, 1'b1, 1'b0, m_rdata, m_r));
        end
    endtask

    initial begin : stim
        int b0, b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", {16'h0, act_vec},
              {16'h0, pack(16'h0, 8'h0, 1'b0, 6'b111111, 1'b1, 1'b0, 8'h0, 7'd0)});
        reset_b = 1'b1;

        b0 = cnt_iorq; b1 = cnt_wr;
        run_cmd(2'b10, 16'h7F00, 8'hC2, 8'h00, 0, 1'b0);
        check("iowr_iorq_low", cnt_iorq - b0, 3);
        check("iowr_wr_low", cnt_wr - b1, 3);
        check("iowr_bus", {adr, data_out, rsp_valid}, {16'h7F00, 8'hC2, 1'b1});
        idle(1);

        b0 = cnt_mreq; b1 = cnt_wr;
        run_cmd(2'b01, 16'hC000, 8'h5A, 8'h00, 0, 1'b0);
        check("memwr_mreq_low", cnt_mreq - b0, 3);
        check("memwr_wr_low", cnt_wr - b1, 2);
        check("memwr_rsp", {rsp_valid, cmd_ready}, 2'b11);
        b0 = cnt_rd;
        run_cmd(2'b00, 16'hC000, 8'h00, 8'h5A, 0, 1'b0);
        check("memrd_rd_low", cnt_rd - b0, 3);
        check("memrd_rdata", {rsp_valid, rsp_rdata}, {1'b1, 8'h5A});
        idle(2);

        b0 = cnt_mreq;
        run_cmd(2'b00, 16'h4000, 8'h00, 8'h96, 2, 1'b0);
        check("memrd_wait_mreq_low", cnt_mreq - b0, 5);
        check("memrd_wait_rdata", {rsp_valid, rsp_rdata}, {1'b1, 8'h96});
        idle(1);

        b0 = cnt_rfsh; b1 = cnt_overlap;
        for (int i = 0; i < 130; i++) begin
            run_cmd(2'b11, 16'h1000 + 16'(i), 8'h00, 8'(i), 0, 1'b0);
        end
        check("m1_rreg_wrap", r_reg, 7'd2);
        check("m1_last_refresh_adr", adr, 16'h0001);
        check("m1_rfsh_low", cnt_rfsh - b0, 260);
        check("m1_rfsh_overlap", cnt_overlap - b1, 0);
        idle(1);

        run_cmd(2'b01, 16'h2345, 8'hA5, 8'h00, 1, 1'b1);
        run_cmd(2'b10, 16'h7F10, 8'hC4, 8'h00, 2, 1'b1);
        idle(3);
        run_cmd(2'b00, 16'h8001, 8'h00, 8'h3C, 1, 1'b1);
        run_cmd(2'b11, 16'h0100, 8'h00, 8'hE1, 2, 1'b1);
        run_cmd(2'b11, 16'h0102, 8'h00, 8'h7E, 0, 1'b1);
        idle(2);

        // Abort a MEMWR in T2 with an asynchronous reset.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 16'h8000; cmd_wdata = 8'h33;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        check("abort_t2_active", {mreq_b, wr_b, data_oe}, 3'b001);
        reset_b = 1'b0;
        #1;
        check("abort_async", {mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, data_oe, rsp_valid, cmd_ready},
              9'b111111001);
        @(posedge clk); #2;
        reset_b = 1'b1;
        m_adr = 16'h0; m_dout = 8'h0; m_rdata = 8'h0; m_r = 7'd0;
        @(negedge clk);
        check("after_reset", {cmd_ready, rsp_valid, r_reg, adr}, {1'b1, 1'b0, 7'd0, 16'h0});
        @(posedge clk); #2;
        run_cmd(2'b00, 16'h0040, 8'h00, 8'h11, 1, 1'b0);
        idle(1);
        @(negedge clk); #1;
        check("queue_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
